// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 data mux among 16 requesters, with burst-limited
// grants and a registered valid/ready output stage feeding a single consumer.
module mux_rr_arbiter #(
   parameter int NUM_REQ   = 16,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4,
   parameter int SEL_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   output logic [SEL_W-1:0]   mux_select,
   input  logic [DATA_W-1:0]  mux_out,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [SEL_W-1:0]   out_src,
   input  logic               out_ready
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

   state_t           state;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] gnt;
   logic [3:0]       beat_cnt;
   logic [3:0]       beat_next;
   logic             stage_free;
   logic             transfer;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;
   logic [SEL_W-1:0] cand;

   assign mux_select = gnt;
   assign stage_free = !out_valid || out_ready;
   assign transfer   = (state == GRANT) && req_valid[gnt] && stage_free;
   assign beat_next  = beat_cnt + 4'd1;

   // Scan downward so the candidate closest to rr_ptr is the last one written.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = rr_ptr + SEL_W'(i);
         if (req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == GRANT)
         req_ready[gnt] = stage_free;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt       <= '0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else begin
         // A new beat may replace the one being popped in the same cycle.
         if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_src   <= gnt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt      <= pick_idx;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (!req_valid[gnt] || (transfer && beat_next == BURST_LAST)) begin
                  state    <= IDLE;
                  rr_ptr   <= gnt + SEL_W'(1);
                  beat_cnt <= '0;
               end else if (transfer) begin
                  beat_cnt <= beat_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
